// File: rtl/dual_input_debouncer.sv
// Two independent switch conditioners. Each channel runs raw -> 2-FF synchronizer -> debounce FSM.
// The FSM accepts a new level only after STABLE_CYCLES consecutive mismatching samples, then pulses rise/fall.
//
// state    | meaning
// STABLE   | synchronized input agrees with the debounced level
// COUNTING | input disagrees; counting consecutive mismatching cycles
module dual_input_debouncer #(
  parameter int STABLE_CYCLES = 50000,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_rise,
  output logic a_fall,
  output logic b_rise,
  output logic b_fall
);

  typedef enum logic {STABLE, COUNTING} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic   [1:0]       raw;
  logic   [1:0]       s1;
  logic   [1:0]       s2;
  logic   [1:0]       lvl;
  logic   [1:0]       rise;
  logic   [1:0]       fall;
  state_t             state [2];
  logic   [CNT_W-1:0] cnt   [2];

  assign raw = {b_raw, a_raw};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= '0;
      s2   <= '0;
      lvl  <= '0;
      rise <= '0;
      fall <= '0;
      for (int i = 0; i < 2; i++) begin
        state[i] <= STABLE;
        cnt[i]   <= '0;
      end
    end else begin
      s1 <= raw;
      s2 <= s1;
      for (int i = 0; i < 2; i++) begin
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        case (state[i])
          STABLE: begin
            if (s2[i] != lvl[i]) begin
              state[i] <= COUNTING;
              cnt[i]   <= CNT_W'(1);
            end else begin
              cnt[i] <= '0;
            end
          end
          COUNTING: begin
            if (s2[i] == lvl[i]) begin
              // A bounce back to the old level forfeits all progress.
              state[i] <= STABLE;
              cnt[i]   <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              state[i] <= STABLE;
              cnt[i]   <= '0;
              lvl[i]   <= s2[i];
              rise[i]  <= s2[i];
              fall[i]  <= ~s2[i];
            end else begin
              cnt[i] <= cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            state[i] <= STABLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

  assign a      = lvl[0];
  assign b      = lvl[1];
  assign a_rise = rise[0];
  assign a_fall = fall[0];
  assign b_rise = rise[1];
  assign b_fall = fall[1];

endmodule
